// File: rtl/siren_driver.sv
// Buzzer cadence generator: a trigger edge starts an episode of tone bursts and gaps,
// paced by the tick_lf strobe; tick_mf times the square-wave tone inside each burst.
module siren_driver #(
    parameter int ON_TICKS      = 200,
    parameter int OFF_TICKS     = 300,
    parameter int MAX_BEEPS     = 10,
    parameter int TONE_HALF     = 2,
    parameter int HOLDOFF_TICKS = 1000,
    parameter int CNT_W         = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_mf,
    input  logic       tick_lf,
    input  logic       trigger,
    input  logic       silence,
    output logic       buzzer,
    output logic       alarm_active,
    output logic [7:0] beep_count
);

    localparam int TONE_W = (TONE_HALF > 1) ? $clog2(TONE_HALF) : 1;

    localparam logic [CNT_W-1:0]  ON_LAST   = CNT_W'(ON_TICKS - 1);
    localparam logic [CNT_W-1:0]  OFF_LAST  = CNT_W'(OFF_TICKS - 1);
    localparam logic [CNT_W-1:0]  HOLD_LAST = CNT_W'(HOLDOFF_TICKS - 1);
    localparam logic [TONE_W-1:0] TONE_LAST = TONE_W'(TONE_HALF - 1);
    localparam logic [7:0]        MAX_B     = 8'(MAX_BEEPS);
    localparam bit                LIMITED   = (MAX_BEEPS != 0);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_BEEP_ON  = 2'd1,
        ST_BEEP_OFF = 2'd2,
        ST_HOLDOFF  = 2'd3
    } state_t;

    state_t            state_q,  state_d;
    logic [CNT_W-1:0]  phase_q,  phase_d;
    logic [TONE_W-1:0] tone_q,   tone_d;
    logic              buzzer_q, buzzer_d;
    logic              alarm_q,  alarm_d;
    logic [7:0]        count_q,  count_d;
    logic              trig_q,   sil_q;

    logic trig_rise;
    logic sil_rise;

    assign trig_rise = trigger & ~trig_q;
    assign sil_rise  = silence & ~sil_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            phase_q  <= '0;
            tone_q   <= '0;
            buzzer_q <= 1'b0;
            alarm_q  <= 1'b0;
            count_q  <= 8'd0;
            trig_q   <= 1'b0;
            sil_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            tone_q   <= tone_d;
            buzzer_q <= buzzer_d;
            alarm_q  <= alarm_d;
            count_q  <= count_d;
            trig_q   <= trigger;
            sil_q    <= silence;
        end
    end

    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        tone_d   = tone_q;
        buzzer_d = buzzer_q;
        count_d  = count_q;

        case (state_q)
            ST_IDLE: begin
                buzzer_d = 1'b0;
                if (trig_rise) begin
                    state_d = ST_BEEP_ON;
                    count_d = 8'd1;
                    phase_d = '0;
                    tone_d  = '0;
                end
            end

            ST_BEEP_ON: begin
                if (sil_rise) begin
                    state_d  = ST_HOLDOFF;
                    phase_d  = '0;
                    buzzer_d = 1'b0;
                end else begin
                    if (tick_mf) begin
                        if (tone_q == TONE_LAST) begin
                            tone_d   = '0;
                            buzzer_d = ~buzzer_q;
                        end else begin
                            tone_d = tone_q + TONE_W'(1);
                        end
                    end
                    // End of burst overrides a same-cycle tone toggle
                    if (tick_lf) begin
                        if (phase_q == ON_LAST) begin
                            state_d  = ST_BEEP_OFF;
                            phase_d  = '0;
                            buzzer_d = 1'b0;
                        end else begin
                            phase_d = phase_q + CNT_W'(1);
                        end
                    end
                end
            end

            ST_BEEP_OFF: begin
                buzzer_d = 1'b0;
                if (sil_rise) begin
                    state_d = ST_HOLDOFF;
                    phase_d = '0;
                end else if (tick_lf) begin
                    if (phase_q == OFF_LAST) begin
                        phase_d = '0;
                        if (LIMITED && (count_q == MAX_B)) begin
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_BEEP_ON;
                            tone_d  = '0;
                            count_d = (count_q == 8'hFF) ? 8'hFF : count_q + 8'd1;
                        end
                    end else begin
                        phase_d = phase_q + CNT_W'(1);
                    end
                end
            end

            ST_HOLDOFF: begin
                buzzer_d = 1'b0;
                if (tick_lf) begin
                    if (phase_q == HOLD_LAST) begin
                        state_d = ST_IDLE;
                        phase_d = '0;
                    end else begin
                        phase_d = phase_q + CNT_W'(1);
                    end
                end
            end

            default: begin
                state_d  = ST_IDLE;
                phase_d  = '0;
                tone_d   = '0;
                buzzer_d = 1'b0;
            end
        endcase

        alarm_d = (state_d == ST_BEEP_ON) || (state_d == ST_BEEP_OFF);
    end

    assign buzzer       = buzzer_q;
    assign alarm_active = alarm_q;
    assign beep_count   = count_q;

endmodule

// File: tb/tb_siren_driver.sv
// Randomised and scenario-driven bench for siren_driver against an event-level model;
// a second instance with unlimited beeps exercises beep_count saturation.
module tb_siren_driver;

    localparam int ON_T   = 3;
    localparam int OFF_T  = 2;
    localparam int MAXB   = 2;
    localparam int TONE_H = 1;
    localparam int HOLD_T = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n = 1'b0, rst2_n = 1'b0;
    logic       tick_mf = 1'b0, tick_lf = 1'b0, tick_lf2 = 1'b0;
    logic       trigger = 1'b0, silence = 1'b0, trig2 = 1'b0, sil2 = 1'b0;
    logic       buzzer, alarm_active, buzzer2, alarm_active2;
    logic [7:0] beep_count, beep_count2;

    siren_driver #(.ON_TICKS(ON_T), .OFF_TICKS(OFF_T), .MAX_BEEPS(MAXB), .TONE_HALF(TONE_H),
                   .HOLDOFF_TICKS(HOLD_T), .CNT_W(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .tick_mf(tick_mf), .tick_lf(tick_lf),
        .trigger(trigger), .silence(silence),
        .buzzer(buzzer), .alarm_active(alarm_active), .beep_count(beep_count));

    siren_driver #(.ON_TICKS(ON_T), .OFF_TICKS(OFF_T), .MAX_BEEPS(0), .TONE_HALF(TONE_H),
                   .HOLDOFF_TICKS(HOLD_T), .CNT_W(8)) u_dut_inf (
        .clk(clk), .rst_n(rst2_n), .tick_mf(tick_mf), .tick_lf(tick_lf2),
        .trigger(trig2), .silence(sil2),
        .buzzer(buzzer2), .alarm_active(alarm_active2), .beep_count(beep_count2));

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // Model state per instance: mode 0=idle 1=tone 2=gap 3=holdoff
    int m_mode[2], m_cnt[2], m_lf[2], m_mf[2], m_buz[2], m_tprev[2], m_sprev[2];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One clock of the alarm rules: ticks counted upward toward the segment length
    task automatic model_step(input int k, input logic rst, input logic tr, input logic si,
                              input logic tmf, input logic tlf, input int maxb);
        bit tr_rise, si_rise;
        if (!rst) begin
            m_mode[k] = 0; m_cnt[k] = 0; m_lf[k] = 0; m_mf[k] = 0;
            m_buz[k] = 0; m_tprev[k] = 0; m_sprev[k] = 0;
            return;
        end
        tr_rise = tr && (m_tprev[k] == 0);
        si_rise = si && (m_sprev[k] == 0);
        m_tprev[k] = int'(tr);
        m_sprev[k] = int'(si);
        case (m_mode[k])
            0: if (tr_rise) begin
                m_mode[k] = 1; m_cnt[k] = 1; m_lf[k] = 0; m_mf[k] = 0; m_buz[k] = 0;
            end
            1: if (si_rise) begin
                m_mode[k] = 3; m_lf[k] = 0; m_buz[k] = 0;
            end else begin
                if (tmf) begin
                    m_mf[k]++;
                    if (m_mf[k] == TONE_H) begin m_mf[k] = 0; m_buz[k] = 1 - m_buz[k]; end
                end
                if (tlf) begin
                    m_lf[k]++;
                    if (m_lf[k] == ON_T) begin m_mode[k] = 2; m_lf[k] = 0; m_buz[k] = 0; end
                end
            end
            2: begin
                m_buz[k] = 0;
                if (si_rise) begin
                    m_mode[k] = 3; m_lf[k] = 0;
                end else if (tlf) begin
                    m_lf[k]++;
                    if (m_lf[k] == OFF_T) begin
                        m_lf[k] = 0;
                        if (maxb != 0 && m_cnt[k] == maxb) m_mode[k] = 0;
                        else begin
                            m_mode[k] = 1; m_mf[k] = 0;
                            m_cnt[k] = (m_cnt[k] >= 255) ? 255 : m_cnt[k] + 1;
                        end
                    end
                end
            end
            default: begin
                m_buz[k] = 0;
                if (tlf) begin
                    m_lf[k]++;
                    if (m_lf[k] == HOLD_T) begin m_mode[k] = 0; m_lf[k] = 0; end
                end
            end
        endcase
    endtask

    always @(posedge clk) begin
        model_step(0, rst_n, trigger, silence, tick_mf, tick_lf, MAXB);
        model_step(1, rst2_n, trig2, sil2, tick_mf, tick_lf2, 0);
    end

    // Advance one clock, compare both instances on the falling edge, set next ticks
    task automatic step();
        @(posedge clk);
        @(negedge clk);
        check_val("buzzer", buzzer, m_buz[0]);
        check_val("alarm_active", alarm_active, (m_mode[0] == 1 || m_mode[0] == 2) ? 1 : 0);
        check_val("beep_count", beep_count, m_cnt[0]);
        check_val("inf_buzzer", buzzer2, m_buz[1]);
        check_val("inf_alarm_active", alarm_active2, (m_mode[1] == 1 || m_mode[1] == 2) ? 1 : 0);
        check_val("inf_beep_count", beep_count2, m_cnt[1]);
        cyc++;
        tick_mf  = (cyc % 2) == 1;
        tick_lf  = (cyc % 10) == 9;
        tick_lf2 = (cyc % 2) == 0;
    endtask

    function automatic bit cond_met(input int id);
        case (id)
            0:       return m_mode[0] == 0;
            1:       return m_mode[0] == 1 && m_cnt[0] == 2;
            2:       return m_mode[0] == 2 && m_cnt[0] == 1;
            3:       return m_mode[0] == 2 && m_lf[0] == OFF_T - 1 && tick_lf;
            default: return m_mode[0] == 1 && m_buz[0] == 1;
        endcase
    endfunction

    task automatic wait_for(input int id, input int budget, input string tag);
        int n = 0;
        while (!cond_met(id) && n < budget) begin
            step();
            n++;
        end
        check_val(tag, 32'(cond_met(id)), 1);
    endtask

    initial begin
        repeat (3) step();
        check_val("reset_buzzer", buzzer, 0);
        check_val("reset_count", beep_count, 0);
        rst_n = 1'b1;
        rst2_n = 1'b1;
        trig2 = 1'b1;
        step();

        // Full two-beep episode ending in idle
        trigger = 1'b1;
        step();
        check_val("s1_start_active", alarm_active, 1);
        check_val("s1_start_count", beep_count, 1);
        wait_for(0, 400, "s1_wait_idle");
        check_val("s1_end_active", alarm_active, 0);
        check_val("s1_end_count", beep_count, 2);
        trigger = 1'b0;
        step();

        // Silence during second tone, trigger ignored in holdoff
        trigger = 1'b1; step(); trigger = 1'b0;
        wait_for(1, 400, "s2_wait_beep2");
        silence = 1'b1;
        step();
        check_val("s2_sil_buzzer", buzzer, 0);
        check_val("s2_sil_active", alarm_active, 0);
        silence = 1'b0;
        repeat (5) step();
        trigger = 1'b1; step(); trigger = 1'b0;
        check_val("s2_holdoff_ignore", alarm_active, 0);
        wait_for(0, 400, "s2_wait_idle");
        trigger = 1'b1; step(); trigger = 1'b0;
        check_val("s2_restart_count", beep_count, 1);

        // Trigger re-pulsed during a gap does not restart the count
        wait_for(2, 400, "s3_wait_gap");
        trigger = 1'b1; step(); trigger = 1'b0; step();
        check_val("s3_count_held", beep_count, 1);
        wait_for(0, 400, "s3_wait_idle");
        check_val("s3_end_count", beep_count, 2);

        // Silence coinciding with the tick that ends the gap
        trigger = 1'b1; step(); trigger = 1'b0;
        wait_for(3, 400, "s4_wait_gap_end");
        silence = 1'b1;
        step();
        check_val("s4_active", alarm_active, 0);
        check_val("s4_count", beep_count, 1);
        silence = 1'b0;
        wait_for(0, 400, "s4_wait_idle");

        // Asynchronous reset while buzzer is high, release with trigger held
        trigger = 1'b1; step();
        wait_for(4, 400, "s5_wait_buzz");
        #2 rst_n = 1'b0;
        #1;
        check_val("s5_async_buzzer", buzzer, 0);
        check_val("s5_async_active", alarm_active, 0);
        check_val("s5_async_count", beep_count, 0);
        step();
        rst_n = 1'b1;
        step();
        check_val("s5_restart_active", alarm_active, 1);
        check_val("s5_restart_count", beep_count, 1);
        trigger = 1'b0;
        wait_for(0, 400, "s5_wait_idle");

        // Random trigger/silence activity
        for (int i = 0; i < 2600; i++) begin
            if ($urandom_range(0, 29) == 0) trigger = ~trigger;
            if ($urandom_range(0, 59) == 0) silence = ~silence;
            step();
        end

        check_val("sat_count", beep_count2, 255);
        check_val("sat_active", alarm_active2, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
